control_sequencer: RTL and testbench

//  Hardwired microsequencer that drives every datapath control wire of the fpg8 top level.
//  It sits upstream of the bus datapath (GPR, IR, MAR, MDR, Y/shifter, ALU, Z) and consumes the IR decode fields.
//  It runs a fixed fetch/decode/execute state machine, one micro-step per one_shot_clock.

---
 rtl/control_sequencer_pkg.sv | 78 +++++++
 rtl/control_sequencer_decode.sv | 139 +++++++++++++
 rtl/control_sequencer.sv | 106 ++++++++++
 tb/tb_control_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared opcode, ALU, GPR-select, state and control-vector definitions
package control_sequencer_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_INC = 3'd7;

    localparam logic [2:0] SEL_RD1 = 3'd0;
    localparam logic [2:0] SEL_RD2 = 3'd1;
    localparam logic [2:0] SEL_RS1 = 3'd2;
    localparam logic [2:0] SEL_RS2 = 3'd3;
    localparam logic [2:0] SEL_PC  = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_F0     = 4'd1,
        ST_F1     = 4'd2,
        ST_F2     = 4'd3,
        ST_F3     = 4'd4,
        ST_DEC    = 4'd5,
        ST_E0     = 4'd6,
        ST_E1     = 4'd7,
        ST_E2     = 4'd8,
        ST_HALTED = 4'd9
    } state_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       gpr_in;
        logic       gpr_out;
        logic [2:0] gpr_select;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       y_in;
        logic       z_in;
        logic       z_out;
        logic       ram_read;
        logic       ram_write;
        logic       y_shift_left;
        logic       y_shift_right;
        logic       instr_done;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_HALT;
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// rtl/control_sequencer_decode.sv - combinational next-state and control-vector decode
module control_decode
    import control_sequencer_pkg::*;
#(
    parameter bit RUN_GATE = 1'b1
) (
    input  logic [3:0] state,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       S,
    input  logic [1:0] shift,
    input  logic [3:0] opcode_held,
    input  logic       S_held,
    input  logic [1:0] shift_held,
    output logic [3:0] next_state,
    output ctrl_t      ctrl,
    output logic       set_halted,
    output logic       set_illegal
);

    logic [3:0] op;
    logic       s_eff;
    logic [1:0] shift_eff;
    logic       no_exec;

    // IR fields are live while entering and leaving DEC; execute steps use the copy captured at DEC.
    always_comb begin
        if ((state == ST_F3) || (state == ST_DEC)) begin
            op        = opcode;
            s_eff     = S;
            shift_eff = shift;
        end else begin
            op        = opcode_held;
            s_eff     = S_held;
            shift_eff = shift_held;
        end
        no_exec = (op == OP_NOP) || is_illegal(op);
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:   next_state = (run || !RUN_GATE) ? ST_F0 : ST_IDLE;
            ST_F0:     next_state = ST_F1;
            ST_F1:     next_state = ST_F2;
            ST_F2:     next_state = ST_F3;
            ST_F3:     next_state = ST_DEC;
            ST_DEC: begin
                if (op == OP_HALT)
                    next_state = ST_HALTED;
                else if (no_exec)
                    next_state = ST_IDLE;
                else
                    next_state = ST_E0;
            end
            ST_E0:     next_state = ST_E1;
            ST_E1:     next_state = ST_E2;
            ST_E2:     next_state = ST_IDLE;
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Controls are computed for the state being entered so they register in alongside it.
    always_comb begin
        ctrl        = '0;
        set_halted  = 1'b0;
        set_illegal = 1'b0;
        case (next_state)
            ST_F0: begin
                ctrl.gpr_select = SEL_PC;
                ctrl.gpr_out    = 1'b1;
                ctrl.mar_in     = 1'b1;
                ctrl.y_in       = 1'b1;
            end
            ST_F1: begin
                ctrl.ram_read    = 1'b1;
                ctrl.alu_control = ALU_INC;
                ctrl.z_in        = 1'b1;
            end
            ST_F2: begin
                ctrl.z_out      = 1'b1;
                ctrl.gpr_select = SEL_PC;
                ctrl.gpr_in     = 1'b1;
            end
            ST_F3: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_DEC: begin
                ctrl.instr_done = no_exec;
                set_illegal     = is_illegal(op);
            end
            ST_E0: begin
                ctrl.gpr_out = 1'b1;
                if (is_alu_op(op)) begin
                    ctrl.gpr_select = SEL_RS2;
                    ctrl.y_in       = 1'b1;
                end else begin
                    ctrl.gpr_select = SEL_RS1;
                    ctrl.mar_in     = 1'b1;
                end
            end
            ST_E1: begin
                if (is_alu_op(op)) begin
                    ctrl.gpr_select    = SEL_RS1;
                    ctrl.gpr_out       = 1'b1;
                    ctrl.alu_control   = alu_code(op);
                    ctrl.z_in          = 1'b1;
                    ctrl.y_shift_left  = !s_eff && (shift_eff != 2'd0);
                    ctrl.y_shift_right = s_eff && (shift_eff != 2'd0);
                end else if (op == OP_LOAD) begin
                    ctrl.ram_read = 1'b1;
                end else begin
                    ctrl.gpr_select = SEL_RD1;
                    ctrl.gpr_out    = 1'b1;
                    ctrl.mdr_in     = 1'b1;
                end
            end
            ST_E2: begin
                ctrl.instr_done = 1'b1;
                if (is_alu_op(op)) begin
                    ctrl.z_out      = 1'b1;
                    ctrl.gpr_select = SEL_RD1;
                    ctrl.gpr_in     = 1'b1;
                end else if (op == OP_LOAD) begin
                    ctrl.mdr_out    = 1'b1;
                    ctrl.gpr_select = SEL_RD1;
                    ctrl.gpr_in     = 1'b1;
                end else begin
                    ctrl.ram_write = 1'b1;
                end
            end
            ST_HALTED: set_halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fpg8 microsequencer top: state, IR-field capture and output registers
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter bit RUN_GATE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [3:0]         opcode,
    input  logic               S,
    input  logic [1:0]         shift,
    output logic [2:0]         ALU_control,
    output logic               GPR_in,
    output logic               GPR_out,
    output logic [2:0]         GPR_select,
    output logic               IR_in,
    output logic               MAR_in,
    output logic               MDR_in,
    output logic               MDR_out,
    output logic               Y_in,
    output logic               Z_in,
    output logic               Z_out,
    output logic               RAM_enable_read,
    output logic               RAM_enable_write,
    output logic               Y_out,
    output logic               Y_offset_in,
    output logic               Y_shift_left,
    output logic               Y_shift_right,
    output logic               halted,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_out
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] opcode_held;
    logic       S_held;
    logic [1:0] shift_held;
    logic       set_halted;
    logic       set_illegal;
    ctrl_t      ctrl_next;
    ctrl_t      ctrl_q;

    control_decode #(
        .RUN_GATE (RUN_GATE)
    ) u_decode (
        .state       (state),
        .run         (run),
        .opcode      (opcode),
        .S           (S),
        .shift       (shift),
        .opcode_held (opcode_held),
        .S_held      (S_held),
        .shift_held  (shift_held),
        .next_state  (next_state),
        .ctrl        (ctrl_next),
        .set_halted  (set_halted),
        .set_illegal (set_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ctrl_q      <= '0;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            opcode_held <= '0;
            S_held      <= 1'b0;
            shift_held  <= '0;
        end else begin
            state      <= next_state;
            ctrl_q     <= ctrl_next;
            halted     <= halted | set_halted;
            illegal_op <= illegal_op | set_illegal;
            if (state == ST_DEC) begin
                opcode_held <= opcode;
                S_held      <= S;
                shift_held  <= shift;
            end
        end
    end

    assign ALU_control      = ctrl_q.alu_control;
    assign GPR_in           = ctrl_q.gpr_in;
    assign GPR_out          = ctrl_q.gpr_out;
    assign GPR_select       = ctrl_q.gpr_select;
    assign IR_in            = ctrl_q.ir_in;
    assign MAR_in           = ctrl_q.mar_in;
    assign MDR_in           = ctrl_q.mdr_in;
    assign MDR_out          = ctrl_q.mdr_out;
    assign Y_in             = ctrl_q.y_in;
    assign Z_in             = ctrl_q.z_in;
    assign Z_out            = ctrl_q.z_out;
    assign RAM_enable_read  = ctrl_q.ram_read;
    assign RAM_enable_write = ctrl_q.ram_write;
    assign Y_shift_left     = ctrl_q.y_shift_left;
    assign Y_shift_right    = ctrl_q.y_shift_right;
    assign instr_done       = ctrl_q.instr_done;
    assign Y_out            = 1'b0;
    assign Y_offset_in      = 1'b0;
    assign state_out        = STATE_W'(state);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer against an instruction-level model
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic [2:0] sel;
        logic gin, gout, irin, marin, mdrin, mdrout, yin, zin, zout;
        logic rd, wr, shl, shr, yout, yoff, done, hlt, ill;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, run, S;
    logic [3:0] opcode;
    logic [1:0] shift;
    logic [2:0] ALU_control, GPR_select;
    logic       GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out, Y_in, Z_in, Z_out;
    logic       RAM_enable_read, RAM_enable_write, Y_out, Y_offset_in;
    logic       Y_shift_left, Y_shift_right, halted, illegal_op, instr_done;
    logic [3:0] state_out;

    int   total = 0;
    int   passed = 0;
    bit   check_en = 1'b0;
    obs_t q[$];
    logic m_halt = 1'b0;
    logic m_ill = 1'b0;
    obs_t expv = '0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .S(S), .shift(shift),
        .ALU_control(ALU_control), .GPR_in(GPR_in), .GPR_out(GPR_out), .GPR_select(GPR_select),
        .IR_in(IR_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out), .Y_in(Y_in),
        .Z_in(Z_in), .Z_out(Z_out), .RAM_enable_read(RAM_enable_read),
        .RAM_enable_write(RAM_enable_write), .Y_out(Y_out), .Y_offset_in(Y_offset_in),
        .Y_shift_left(Y_shift_left), .Y_shift_right(Y_shift_right), .halted(halted),
        .illegal_op(illegal_op), .instr_done(instr_done), .state_out(state_out)
    );

    function automatic obs_t observe();
        obs_t o;
        o.st = state_out;   o.alu = ALU_control; o.sel = GPR_select;
        o.gin = GPR_in;     o.gout = GPR_out;    o.irin = IR_in;
        o.marin = MAR_in;   o.mdrin = MDR_in;    o.mdrout = MDR_out;
        o.yin = Y_in;       o.zin = Z_in;        o.zout = Z_out;
        o.rd = RAM_enable_read; o.wr = RAM_enable_write;
        o.shl = Y_shift_left;   o.shr = Y_shift_right;
        o.yout = Y_out;     o.yoff = Y_offset_in; o.done = instr_done;
        o.hlt = halted;     o.ill = illegal_op;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Expected micro-step sequence of one whole instruction, from IDLE exit back to IDLE.
    task automatic build(input logic [3:0] op, input logic s, input logic [1:0] sh);
        obs_t t;
        bit   alu_op = (op >= 1) && (op <= 5);
        t = '0; t.st = 1; t.sel = 4; t.gout = 1; t.marin = 1; t.yin = 1; q.push_back(t);
        t = '0; t.st = 2; t.rd = 1; t.alu = 7; t.zin = 1;                q.push_back(t);
        t = '0; t.st = 3; t.zout = 1; t.sel = 4; t.gin = 1;              q.push_back(t);
        t = '0; t.st = 4; t.mdrout = 1; t.irin = 1;                      q.push_back(t);
        t = '0; t.st = 5;
        if (op == 0 || op >= 9) begin
            t.done = 1; t.ill = (op >= 9); q.push_back(t);
            t = '0; q.push_back(t);
            return;
        end
        q.push_back(t);
        if (op == 8) begin
            t = '0; t.st = 9; t.hlt = 1; q.push_back(t);
            return;
        end
        t = '0; t.st = 6; t.gout = 1;
        if (alu_op) begin t.sel = 3; t.yin = 1; end
        else begin t.sel = 2; t.marin = 1; end
        q.push_back(t);
        t = '0; t.st = 7;
        if (alu_op) begin
            t.sel = 2; t.gout = 1; t.zin = 1;
            case (op)
                1: t.alu = 0;
                2: t.alu = 1;
                3: t.alu = 2;
                4: t.alu = 3;
                default: t.alu = 4;
            endcase
            t.shl = !s && (sh != 0);
            t.shr = s && (sh != 0);
        end else if (op == 6) t.rd = 1;
        else begin t.sel = 0; t.gout = 1; t.mdrin = 1; end
        q.push_back(t);
        t = '0; t.st = 8; t.done = 1;
        if (alu_op) begin t.zout = 1; t.sel = 0; t.gin = 1; end
        else if (op == 6) begin t.mdrout = 1; t.sel = 0; t.gin = 1; end
        else t.wr = 1;
        q.push_back(t);
        t = '0; q.push_back(t);
    endtask

    always @(posedge clk) begin
        obs_t t;
        if (!reset) begin
            q.delete();
            m_halt = 1'b0;
            m_ill  = 1'b0;
            expv   = '0;
        end else begin
            if (q.size() == 0 && !m_halt && run) build(opcode, S, shift);
            if (q.size() != 0) t = q.pop_front();
            else begin
                t = '0;
                if (m_halt) t.st = 9;
            end
            m_halt = m_halt | t.hlt;
            m_ill  = m_ill | t.ill;
            t.hlt  = m_halt;
            t.ill  = m_ill;
            expv   = t;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_model", 32'(observe()), 32'(expv));
            chk("bus_exclusive", 32'(($countones({GPR_out, MDR_out, Z_out, Y_out}) <= 1)
                                     && !(GPR_in && GPR_out)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] op, input logic s, input logic [1:0] sh);
        opcode = op; S = s; shift = sh; run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; opcode = '0; S = 1'b0; shift = '0;
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_idle_state", 32'(state_out), 32'd0);
            chk("reset_idle_outputs", 32'(observe()), 32'd0);
        end

        start(4'd1, 1'b0, 2'd2);
        chk("add_f0_sel", 32'(GPR_select), 32'd4);
        chk("add_f0_strobes", 32'({GPR_out, MAR_in, Y_in}), 32'h7);
        repeat (6) tick();
        chk("add_e1_alu", 32'(ALU_control), 32'd0);
        chk("add_e1_shift", 32'({Y_shift_left, Y_shift_right, Z_in}), 32'h5);
        chk("add_e1_no_done", 32'(instr_done), 32'd0);
        tick();
        chk("add_done_cycle9", 32'(instr_done), 32'd1);
        repeat (3) tick();
        chk("run_low_holds_idle", 32'(state_out), 32'd0);

        start(4'd7, 1'b0, 2'd0);
        repeat (6) tick();
        chk("store_e1", 32'({GPR_select, GPR_out, MDR_in}), 32'({3'd0, 1'b1, 1'b1}));
        tick();
        chk("store_e2_write", 32'({RAM_enable_write, instr_done}), 32'h3);
        repeat (2) tick();

        start(4'd8, 1'b0, 2'd0);
        repeat (5) tick();
        chk("halt_flag", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            run = ~run;
            tick();
            chk("halt_hold_state", 32'(state_out), 32'd9);
        end
        run = 1'b0; reset = 1'b0;
        tick();
        chk("halt_cleared", 32'({halted, state_out}), 32'd0);
        reset = 1'b1;
        tick();

        start(4'd12, 1'b1, 2'd1);
        repeat (4) tick();
        chk("illegal_dec", 32'({illegal_op, instr_done, state_out}), 32'({2'b11, 4'd5}));
        tick();
        chk("illegal_back_idle", 32'({instr_done, state_out}), 32'd0);
        repeat (5) tick();
        chk("illegal_sticky", 32'(illegal_op), 32'd1);

        start(4'd6, 1'b0, 2'd0);
        repeat (6) tick();
        chk("load_e1_read", 32'(RAM_enable_read), 32'd1);
        reset = 1'b0;
        tick();
        chk("load_reset_all_zero", 32'(observe()), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 800; i++) begin
            if (m_halt) reset = 1'b0;
            else reset = ($urandom_range(0, 63) != 0);
            run = ($urandom_range(0, 2) != 0);
            if (q.size() == 0) begin
                opcode = 4'($urandom_range(0, 15));
                S      = 1'($urandom_range(0, 1));
                shift  = 2'($urandom_range(0, 3));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
